// File: rtl/memory_bus_arbiter_pkg.sv
// rtl/memory_bus_arbiter_pkg.sv - shared state and owner encodings for the memory bus arbiter
package memory_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

endpackage

// File: rtl/bus_arbiter_select.sv
// rtl/bus_arbiter_select.sv - CPU/DMA winner selection with a saturating CPU streak counter
module bus_arbiter_select #(
    parameter int CPU_HOLD_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic cpu_req,
    input  logic dma_req,
    output logic grant_valid,
    output logic grant_owner
);
    import memory_bus_arbiter_pkg::*;

    localparam int SW = (CPU_HOLD_MAX < 1) ? 1 : $clog2(CPU_HOLD_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_HOLD_MAX);

    logic [SW-1:0] streak_q, streak_d;
    logic          dma_wins;

    // The streak only moves on cycles where the arbiter actually grants (IDLE).
    always_comb begin
        dma_wins    = dma_req && (!cpu_req || (streak_q == STREAK_MAX));
        grant_valid = cpu_req || dma_req;
        grant_owner = dma_wins ? OWNER_DMA : OWNER_CPU;
        streak_d    = streak_q;
        if (sample) begin
            if (!dma_req || dma_wins) begin
                streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - shares one memory bus between CPU and DMA, sequencing each access
module memory_bus_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CPU_HOLD_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_data_in,
    input  logic                  cpu_write_enable,
    output logic [DATA_WIDTH-1:0] cpu_data_out,
    output logic                  cpu_ready,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic [DATA_WIDTH-1:0] dma_data_in,
    input  logic                  dma_write_enable,
    output logic [DATA_WIDTH-1:0] dma_data_out,
    output logic                  dma_ready,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_enable,
    output logic                  bus_write_enable,
    output logic                  busy,
    output logic                  bus_owner
);
    import memory_bus_arbiter_pkg::*;

    localparam int WW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(READ_LATENCY - 1);

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0]   dma_rdata_q, dma_rdata_d;
    logic                    grant_valid;
    logic                    grant_owner;

    bus_arbiter_select #(
        .CPU_HOLD_MAX (CPU_HOLD_MAX)
    ) u_select (
        .clk         (clk),
        .reset       (reset),
        .sample      (state_q == ST_IDLE),
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        we_d             = we_q;
        wait_d           = wait_q;
        cpu_rdata_d      = cpu_rdata_q;
        dma_rdata_d      = dma_rdata_q;
        bus_address      = '0;
        bus_data_in      = '0;
        bus_enable       = 1'b0;
        bus_write_enable = 1'b0;
        cpu_ready        = 1'b0;
        dma_ready        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    if (grant_owner == OWNER_DMA) begin
                        addr_d  = dma_address;
                        wdata_d = dma_data_in;
                        we_d    = dma_write_enable;
                    end else begin
                        addr_d  = cpu_address;
                        wdata_d = cpu_data_in;
                        we_d    = cpu_write_enable;
                    end
                    state_d = ST_ACCESS;
                end
            end
            // The only cycle with a bus strobe; peripherals see exactly one.
            ST_ACCESS: begin
                bus_address      = addr_q;
                bus_data_in      = wdata_q;
                bus_enable       = 1'b1;
                bus_write_enable = we_q;
                wait_d           = WAIT_LAST;
                state_d          = we_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                bus_address = addr_q;
                bus_data_in = wdata_q;
                if (wait_q == '0) begin
                    if (owner_q == OWNER_DMA) begin
                        dma_rdata_d = bus_data_out;
                    end else begin
                        cpu_rdata_d = bus_data_out;
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            ST_DONE: begin
                bus_address = addr_q;
                bus_data_in = wdata_q;
                cpu_ready   = (owner_q == OWNER_CPU);
                dma_ready   = (owner_q == OWNER_DMA);
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_CPU;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            wait_q      <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign bus_owner    = busy ? owner_q : OWNER_CPU;
    assign cpu_data_out = cpu_rdata_q;
    assign dma_data_out = dma_rdata_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb/tb_memory_bus_arbiter.sv - self-checking bench for memory_bus_arbiter
module tb_memory_bus_arbiter;

    localparam int RL   = 1;
    localparam int HOLD = 4;
    localparam int RL0  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    logic        reset;
    logic        cpu_req, cpu_write_enable, cpu_ready;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_in, cpu_data_out;
    logic        dma_req, dma_write_enable, dma_ready;
    logic [15:0] dma_address;
    logic [7:0]  dma_data_in, dma_data_out;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_in, bus_data_out;
    logic        bus_enable, bus_write_enable, busy, bus_owner;

    logic        z_cpu_req, z_dma_req, z_cpu_ready, z_dma_ready;
    logic [15:0] z_cpu_address = 16'h0100;
    logic [15:0] z_dma_address = 16'h0200;
    logic [7:0]  z_data_in = 8'h00;
    logic        z_we = 1'b0;
    logic [7:0]  z_cpu_data_out, z_dma_data_out, z_bus_data_in;
    logic [7:0]  z_bus_data_out = 8'h77;
    logic [15:0] z_bus_address;
    logic        z_bus_enable, z_bus_write_enable, z_busy, z_bus_owner;

    memory_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(RL), .CPU_HOLD_MAX(HOLD)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
        .cpu_write_enable(cpu_write_enable), .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_address(dma_address), .dma_data_in(dma_data_in),
        .dma_write_enable(dma_write_enable), .dma_data_out(dma_data_out), .dma_ready(dma_ready),
        .bus_address(bus_address), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .bus_enable(bus_enable), .bus_write_enable(bus_write_enable), .busy(busy), .bus_owner(bus_owner)
    );

    memory_bus_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(RL0), .CPU_HOLD_MAX(0)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(z_cpu_req), .cpu_address(z_cpu_address), .cpu_data_in(z_data_in),
        .cpu_write_enable(z_we), .cpu_data_out(z_cpu_data_out), .cpu_ready(z_cpu_ready),
        .dma_req(z_dma_req), .dma_address(z_dma_address), .dma_data_in(z_data_in),
        .dma_write_enable(z_we), .dma_data_out(z_dma_data_out), .dma_ready(z_dma_ready),
        .bus_address(z_bus_address), .bus_data_in(z_bus_data_in), .bus_data_out(z_bus_data_out),
        .bus_enable(z_bus_enable), .bus_write_enable(z_bus_write_enable), .busy(z_busy), .bus_owner(z_bus_owner)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Bus-side memory: read data appears READ_LATENCY cycles after the strobe, garbage otherwise.
    logic [7:0] bus_mem [int];
    int         pend_cnt = 0;
    logic [7:0] pend_data = 8'h00;
    assign bus_data_out = (pend_cnt == 1) ? pend_data : 8'hEE;

    initial begin
        bus_mem[32'h4010] = 8'h3C;
        forever begin
            @(posedge clk);
            if (bus_enable && bus_write_enable) bus_mem[int'(bus_address)] = bus_data_in;
            if (bus_enable && !bus_write_enable) begin
                pend_cnt  <= RL;
                pend_data <= bus_mem.exists(int'(bus_address)) ? bus_mem[int'(bus_address)] : dflt(bus_address);
            end else if (pend_cnt > 0) begin
                pend_cnt <= pend_cnt - 1;
            end
        end
    end

    // Event monitor: strobe/ready counts and grant history.
    int    strobes = 0, wstrobes = 0, cpu_rdy_n = 0, dma_rdy_n = 0, last_strobe_cyc = -1;
    logic [15:0] last_addr = 16'h0;
    string glog = "";
    string zlog = "";
    int    z_cycles[$];
    int    z_bad_strobe = 0, z_cpu_rdy_n = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus_enable) begin
                strobes++;
                if (bus_write_enable) wstrobes++;
                last_addr = bus_address;
                last_strobe_cyc = tcyc;
                glog = {glog, bus_owner ? "D" : "C"};
            end
            if (cpu_ready) cpu_rdy_n++;
            if (dma_ready) dma_rdy_n++;
            if (z_bus_enable) begin
                zlog = {zlog, z_bus_owner ? "D" : "C"};
                z_cycles.push_back(tcyc);
                if (z_bus_write_enable || z_bus_address != 16'h0200 || z_bus_data_in != 8'h00) z_bad_strobe++;
            end
            if (z_cpu_ready) z_cpu_rdy_n++;
        end
    end

    // Transaction-level model: an access granted in IDLE cycle t0 strobes at t0+1,
    // completes at t0+L (L = 2 for writes, 2+RL for reads) and frees the bus at t0+L+1.
    logic [7:0]  model_mem [int];
    bit          m_active = 0, m_owner = 0, m_we = 0;
    int          m_t0 = 0, m_len = 0, m_streak = 0;
    logic [15:0] m_addr = 16'h0;
    logic [7:0]  m_data = 8'h0, m_rd = 8'h0, m_cpu_out = 8'h0, m_dma_out = 8'h0;

    initial begin : model_cmp
        int rel;
        logic e_en, e_crdy, e_drdy;
        model_mem[32'h4010] = 8'h3C;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_active = 0; m_streak = 0; m_cpu_out = 8'h0; m_dma_out = 8'h0;
                check("rst_busy", busy, 0);
                check("rst_en", bus_enable, 0);
                check("rst_we", bus_write_enable, 0);
                check("rst_addr", bus_address, 0);
                check("rst_din", bus_data_in, 0);
                check("rst_rdy", {cpu_ready, dma_ready}, 0);
                check("rst_dout", {cpu_data_out, dma_data_out}, 0);
                check("rst_owner", bus_owner, 0);
                continue;
            end
            rel = tcyc - m_t0;
            if (m_active && rel > m_len) m_active = 0;
            if (m_active && !m_we && rel == m_len) begin
                if (m_owner) m_dma_out = m_rd; else m_cpu_out = m_rd;
            end
            e_en   = m_active && (rel == 1);
            e_crdy = m_active && (rel == m_len) && !m_owner;
            e_drdy = m_active && (rel == m_len) && m_owner;
            check("busy", busy, m_active);
            check("bus_en", bus_enable, e_en);
            check("bus_we", bus_write_enable, e_en && m_we);
            check("cpu_ready", cpu_ready, e_crdy);
            check("dma_ready", dma_ready, e_drdy);
            check("cpu_dout", cpu_data_out, m_cpu_out);
            check("dma_dout", dma_data_out, m_dma_out);
            if (m_active) check("owner", bus_owner, m_owner);
            if (!m_active) begin
                check("idle_addr", bus_address, 0);
                check("idle_din", bus_data_in, 0);
            end else if (rel < m_len) begin
                check("bus_addr", bus_address, m_addr);
            end
            if (e_en) check("bus_din", bus_data_in, m_data);
            if (!m_active && !dma_req) m_streak = 0;
            if (!m_active && (cpu_req || dma_req)) begin
                if (dma_req && (!cpu_req || m_streak >= HOLD)) begin
                    m_owner = 1; m_streak = 0;
                    m_addr = dma_address; m_data = dma_data_in; m_we = dma_write_enable;
                end else begin
                    m_owner = 0;
                    if (dma_req && m_streak < HOLD) m_streak++;
                    m_addr = cpu_address; m_data = cpu_data_in; m_we = cpu_write_enable;
                end
                m_t0 = tcyc; m_active = 1; m_len = m_we ? 2 : 2 + RL;
                if (m_we) model_mem[int'(m_addr)] = m_data;
                else m_rd = model_mem.exists(int'(m_addr)) ? model_mem[int'(m_addr)] : dflt(m_addr);
            end
        end
    end

    task automatic wait_ready(input bit is_dma, output int rc);
        rc = -1000;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (is_dma ? dma_ready : cpu_ready) begin
                rc = tcyc;
                return;
            end
        end
        check(is_dma ? "dma_ready_timeout" : "cpu_ready_timeout", 0, 1);
    endtask

    task automatic run_one(input bit is_dma, input bit we, input logic [15:0] a,
                           input logic [7:0] d, output int lat);
        int s, rc;
        @(posedge clk); #1;
        s = tcyc;
        if (is_dma) begin
            dma_req = 1; dma_address = a; dma_data_in = d; dma_write_enable = we;
        end else begin
            cpu_req = 1; cpu_address = a; cpu_data_in = d; cpu_write_enable = we;
        end
        wait_ready(is_dma, rc);
        @(posedge clk); #1;
        cpu_req = 0; dma_req = 0;
        lat = rc - s;
    endtask

    initial begin : stim
        int lat, c0, rc, s0, w0, r0, gstart;
        reset = 0;
        cpu_req = 1; cpu_address = 16'h1111; cpu_data_in = 8'h11; cpu_write_enable = 1;
        dma_req = 1; dma_address = 16'h2222; dma_data_in = 8'h22; dma_write_enable = 0;
        z_cpu_req = 0; z_dma_req = 0;

        // Reset held with both requests high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold_busy", busy, 0);
        check("reset_hold_en", bus_enable, 0);
        @(posedge clk); #1;
        reset = 1;
        c0 = tcyc;
        wait_ready(0, rc);
        @(posedge clk); #1;
        cpu_req = 0; dma_req = 0;
        check("first_access_cycle", last_strobe_cyc, c0 + 1);
        check("first_ready_cycle", rc - c0, 2);

        // CPU write 0x2000 <= 0xA5.
        s0 = strobes; w0 = wstrobes;
        run_one(0, 1, 16'h2000, 8'hA5, lat);
        check("wr_latency", lat, 2);
        check("wr_strobes", strobes - s0, 1);
        check("wr_wstrobes", wstrobes - w0, 1);
        check("wr_addr", last_addr, 16'h2000);
        check("wr_mem", bus_mem[32'h2000], 8'hA5);
        check("wr_cpu_dout", cpu_data_out, 8'h00);

        // DMA read 0x4010 returns 0x3C.
        w0 = wstrobes;
        run_one(1, 0, 16'h4010, 8'h00, lat);
        check("rd_latency", lat, 3);
        check("rd_dma_dout", dma_data_out, 8'h3C);
        check("rd_no_write", wstrobes - w0, 0);
        repeat (3) @(posedge clk);
        #1 check("rd_dma_hold", dma_data_out, 8'h3C);

        // CPU reads back its own write.
        run_one(0, 0, 16'h2000, 8'h00, lat);
        check("rd2_latency", lat, 3);
        check("rd2_cpu_dout", cpu_data_out, 8'hA5);
        check("rd2_dma_untouched", dma_data_out, 8'h3C);

        // Continuous contention: bounded CPU priority.
        @(posedge clk); #1;
        gstart = glog.len();
        cpu_req = 1; cpu_address = 16'h3000; cpu_data_in = 8'h5A; cpu_write_enable = 1;
        dma_req = 1; dma_address = 16'h4010; dma_data_in = 8'h00; dma_write_enable = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (glog.len() - gstart >= 10) break;
        end
        cpu_req = 0; dma_req = 0;
        check("tie_grants", glog.len() - gstart, 10);
        total++;
        if (glog.len() - gstart < 10 || glog.substr(gstart, gstart + 9) != "CCCCDCCCCD") begin
            bad++;
            $display("FAIL tie_order: got %s want CCCCDCCCCD", glog.substr(gstart, glog.len() - 1));
        end
        repeat (6) @(posedge clk);

        // CPU drops req while its read sits in WAIT.
        s0 = strobes; r0 = cpu_rdy_n;
        @(posedge clk); #1;
        cpu_req = 1; cpu_address = 16'h4010; cpu_write_enable = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cpu_req = 0;
        repeat (6) @(posedge clk);
        #1;
        check("drop_strobes", strobes - s0, 1);
        check("drop_ready", cpu_rdy_n - r0, 1);
        check("drop_cpu_dout", cpu_data_out, 8'h3C);

        // Reset during WAIT, then a fresh read.
        @(posedge clk); #1;
        dma_req = 1; dma_address = 16'h2000; dma_write_enable = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0; dma_req = 0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_ready", dma_ready, 0);
        check("abort_en", bus_enable, 0);
        check("abort_addr", bus_address, 0);
        @(posedge clk); #1;
        reset = 1;
        run_one(1, 0, 16'h2000, 8'h00, lat);
        check("post_reset_latency", lat, 3);
        check("post_reset_dout", dma_data_out, 8'hA5);

        // CPU_HOLD_MAX = 0, READ_LATENCY = 2 instance: DMA wins every tie, reads spaced 5 apart.
        @(posedge clk); #1;
        z_cpu_req = 1; z_dma_req = 1;
        repeat (30) @(posedge clk);
        #1;
        z_cpu_req = 0; z_dma_req = 0;
        repeat (8) @(posedge clk);
        #1;
        check("z_grants", (z_cycles.size() >= 5), 1);
        total++;
        if (zlog.len() < 5 || zlog.substr(0, 4) != "DDDDD") begin
            bad++;
            $display("FAIL z_order: got %s want DDDDD...", zlog);
        end
        for (int i = 1; i < 5 && i < z_cycles.size(); i++)
            check("z_spacing", z_cycles[i] - z_cycles[i-1], 5);
        check("z_dma_dout", z_dma_data_out, 8'h77);
        check("z_cpu_dout", z_cpu_data_out, 8'h00);
        check("z_cpu_ready", z_cpu_rdy_n, 0);
        check("z_strobe_fields", z_bad_strobe, 0);
        check("z_idle", {z_busy, z_dma_ready, z_cpu_ready}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
